// File: rtl/i2s_rx.sv
// i2s_rx: I2S (Philips) receiver oversampled on clk, emits coherent left/right pairs with a valid strobe.
// Optional frame check enabled by defining I2S_RX_FRAMECHECK_EN.
module i2s_rx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bck,
  input  logic             lrck,
  input  logic             din,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {HUNT, RECV, TAIL} state_t;
  state_t state, state_n;
  logic [2:0] bck_q;
  logic [1:0] lr_q, d_q;
  logic rise, ls, ds, seen, ls_prev, chan, have_left;
  logic lr_edge, word_done, latch_l, latch_r, discard;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg, lhold, shnext;
  assign ls = lr_q[1];
  assign ds = d_q[1];
  assign shnext = {shreg[WIDTH-2:0], ds};
  // the first event after reset has no predecessor, so it can never be an edge
  assign lr_edge = rise && seen && (ls != ls_prev);
  assign word_done = rise && !lr_edge && state == RECV && bit_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bck_q <= '0;
      lr_q  <= '0;
      d_q   <= '0;
      rise  <= 1'b0;
    end else begin
      bck_q <= {bck_q[1:0], bck};
      lr_q  <= {lr_q[0], lrck};
      d_q   <= {d_q[0], din};
      rise  <= bck_q[1] & ~bck_q[2];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_n;
  end
  always_comb begin
    state_n = lr_edge ? RECV : word_done ? TAIL : state;
  end
  always_comb begin
    latch_l = word_done && !chan;
    latch_r = word_done && chan && have_left;
    discard = lr_edge && state == RECV;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= 1'b0;
      ls_prev   <= 1'b0;
      chan      <= 1'b0;
      have_left <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      lhold     <= '0;
      left      <= '0;
      right     <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= latch_r;
      if (rise) begin
        seen    <= 1'b1;
        ls_prev <= ls;
      end
      if (lr_edge) begin
        bit_cnt <= '0;
        chan    <= ls;
      end else if (rise && state == RECV) begin
        shreg   <= shnext;
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (latch_l) lhold <= shnext;
      if (latch_r) begin
        left  <= lhold;
        right <= shnext;
      end
      have_left <= latch_l ? 1'b1 : (discard || (word_done && chan)) ? 1'b0 : have_left;
    end
  end
`ifdef I2S_RX_FRAMECHECK_EN
  logic [7:0] slot_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      frame_err <= 1'b0;
    end else if (rise) begin
      if (lr_edge) begin
        slot_cnt <= 8'd1;
        if (state != HUNT && slot_cnt != 8'(SLOT)) frame_err <= 1'b1;
      end else if (slot_cnt != 8'hff) begin
        slot_cnt <= slot_cnt + 8'd1;
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed I2S frame stimulus with hand-computed expected samples.
`timescale 1ns/1ps
module tb_i2s_rx;
  logic clk = 1'b0, rst = 1'b1, bck = 1'b0, lrck = 1'b1, din = 1'b0;
  logic [15:0] left, right;
  logic valid, frame_err;
  int asserts = 0, fails = 0;
  logic [15:0] cl[$], cr[$];
`ifdef I2S_RX_FRAMECHECK_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  i2s_rx #(.WIDTH(16), .SLOT(32)) dut (
    .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .din(din),
    .left(left), .right(right), .valid(valid), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (valid) begin
    cl.push_back(left);
    cr.push_back(right);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] get_l(input int i);
    return (i < cl.size()) ? cl[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] get_r(input int i);
    return (i < cr.size()) ? cr[i] : 16'hxxxx;
  endfunction

  // bit k of a slot: k=0 carries the previous LSB/padding, k=1..16 data MSB first, rest padding
  task automatic send_bits(input logic ch, input logic [15:0] d, input logic pad, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      bck = 1'b0;
      lrck = ch;
      din = (k >= 1 && k <= 16) ? d[16-k] : pad;
      repeat (7) @(negedge clk);
      bck = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic slot(input logic ch, input logic [15:0] d, input logic pad);
    send_bits(ch, d, pad, 0, 31);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (4) begin
        @(negedge clk);
        bck = 1'($urandom);
        lrck = 1'($urandom);
        din = 1'($urandom);
      end
      asserts++;
      if ({left, right, valid, frame_err} !== 34'b0) begin
        fails++;
        $display("FAIL reset_hold: got l=%h r=%h v=%b fe=%b, want all zero", left, right, valid, frame_err);
      end
    end
    @(negedge clk);
    bck = 1'b0;
    lrck = 1'b1;
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    int b;
    b = cl.size();
    slot(1'b1, 16'hDEAD, 1'b0);
    slot(1'b0, 16'h1234, 1'b0);
    slot(1'b1, 16'hABCD, 1'b0);
    slot(1'b0, 16'h8001, 1'b0);
    slot(1'b1, 16'h7FFE, 1'b0);
    asserts++;
    if (cl.size() - b !== 2) begin fails++; $display("FAIL nominal_count: got %0d pulses, want 2", cl.size() - b); end
    asserts++;
    if (get_l(b) !== 16'h1234) begin fails++; $display("FAIL nominal_l0: got %h want 1234", get_l(b)); end
    asserts++;
    if (get_r(b) !== 16'hABCD) begin fails++; $display("FAIL nominal_r0: got %h want abcd", get_r(b)); end
    asserts++;
    if (get_l(b + 1) !== 16'h8001) begin fails++; $display("FAIL nominal_l1: got %h want 8001", get_l(b + 1)); end
    asserts++;
    if (get_r(b + 1) !== 16'h7FFE) begin fails++; $display("FAIL nominal_r1: got %h want 7ffe", get_r(b + 1)); end
    asserts++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL nominal_fe: got %b want 0", frame_err); end
  endtask

  task automatic test_padding;
    int b;
    b = cl.size();
    slot(1'b0, 16'h0000, 1'b1);
    slot(1'b1, 16'h0001, 1'b1);
    asserts++;
    if (cl.size() - b !== 1) begin fails++; $display("FAIL pad_count: got %0d pulses, want 1", cl.size() - b); end
    asserts++;
    if (get_l(b) !== 16'h0000) begin fails++; $display("FAIL pad_l: got %h want 0000", get_l(b)); end
    asserts++;
    if (get_r(b) !== 16'h0001) begin fails++; $display("FAIL pad_r: got %h want 0001", get_r(b)); end
    asserts++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL pad_fe: got %b want 0", frame_err); end
  endtask

  task automatic test_short_slot;
    int b;
    b = cl.size();
    send_bits(1'b0, 16'hAAAA, 1'b0, 0, 9);
    slot(1'b1, 16'h1111, 1'b0);
    asserts++;
    if (cl.size() - b !== 0) begin fails++; $display("FAIL short_dropped: got %0d pulses, want 0", cl.size() - b); end
    asserts++;
    if (frame_err !== FE) begin fails++; $display("FAIL short_fe: got %b want %b", frame_err, FE); end
    slot(1'b0, 16'h2222, 1'b0);
    slot(1'b1, 16'h3333, 1'b0);
    asserts++;
    if (cl.size() - b !== 1) begin fails++; $display("FAIL short_recover_count: got %0d pulses, want 1", cl.size() - b); end
    asserts++;
    if (get_l(b) !== 16'h2222) begin fails++; $display("FAIL short_l: got %h want 2222", get_l(b)); end
    asserts++;
    if (get_r(b) !== 16'h3333) begin fails++; $display("FAIL short_r: got %h want 3333", get_r(b)); end
    asserts++;
    if (frame_err !== FE) begin fails++; $display("FAIL short_fe_sticky: got %b want %b", frame_err, FE); end
  endtask

  task automatic test_mid_frame;
    int b;
    rst = 1'b1;
    @(negedge clk);
    asserts++;
    if ({left, right, valid, frame_err} !== 34'b0) begin
      fails++;
      $display("FAIL midframe_rst: got l=%h r=%h v=%b fe=%b, want all zero", left, right, valid, frame_err);
    end
    send_bits(1'b1, 16'h5555, 1'b0, 0, 15);
    rst = 1'b0;
    b = cl.size();
    send_bits(1'b1, 16'h5555, 1'b0, 16, 31);
    slot(1'b0, 16'h0F0F, 1'b0);
    asserts++;
    if (cl.size() - b !== 0) begin fails++; $display("FAIL midframe_early: got %0d pulses, want 0", cl.size() - b); end
    slot(1'b1, 16'hF0F0, 1'b0);
    asserts++;
    if (cl.size() - b !== 1) begin fails++; $display("FAIL midframe_count: got %0d pulses, want 1", cl.size() - b); end
    asserts++;
    if (get_l(b) !== 16'h0F0F) begin fails++; $display("FAIL midframe_l: got %h want 0f0f", get_l(b)); end
    asserts++;
    if (get_r(b) !== 16'hF0F0) begin fails++; $display("FAIL midframe_r: got %h want f0f0", get_r(b)); end
    asserts++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL midframe_fe: got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid_op;
    int b;
    slot(1'b0, 16'h4444, 1'b0);
    send_bits(1'b1, 16'h5A5A, 1'b0, 0, 8);
    rst = 1'b1;
    @(negedge clk);
    asserts++;
    if (left !== 16'h0) begin fails++; $display("FAIL rstop_l: got %h want 0000", left); end
    asserts++;
    if (right !== 16'h0) begin fails++; $display("FAIL rstop_r: got %h want 0000", right); end
    asserts++;
    if (valid !== 1'b0) begin fails++; $display("FAIL rstop_v: got %b want 0", valid); end
    @(negedge clk);
    rst = 1'b0;
    b = cl.size();
    send_bits(1'b1, 16'h5A5A, 1'b0, 9, 31);
    slot(1'b0, 16'h6666, 1'b0);
    slot(1'b1, 16'h7777, 1'b0);
    asserts++;
    if (cl.size() - b !== 1) begin fails++; $display("FAIL rstop_count: got %0d pulses, want 1", cl.size() - b); end
    asserts++;
    if (get_l(b) !== 16'h6666) begin fails++; $display("FAIL rstop_next_l: got %h want 6666", get_l(b)); end
    asserts++;
    if (get_r(b) !== 16'h7777) begin fails++; $display("FAIL rstop_next_r: got %h want 7777", get_r(b)); end
    asserts++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL rstop_fe: got %b want 0", frame_err); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_padding;
    test_short_slot;
    test_mid_frame;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
